// File: rtl/fifo_sync_param_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // Occupancy must represent 0..depth inclusive, hence one bit beyond the address width.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Data, handshake and status bundle for fifo_sync_param; signal names match fifo_if.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 16
);
    localparam int CW = fifo_cnt_w(DEPTH);

    logic [DW-1:0] din;
    logic          we;
    logic          re;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    modport master (
        output din, we, re,
        input  dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  din, we, re,
        output dout, empty, full, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_ram.sv
// DW x DEPTH storage: synchronous write port, asynchronous read port.
module fifo_ram #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count,
// overflow/underflow pulses and a choice of registered or fall-through output.
module fifo_sync_param
  import fifo_pkg::*;
#(
    parameter int         DW        = 32,
    parameter int         DEPTH     = 16,
    parameter int         AFULL_TH  = DEPTH - 2,
    parameter int         AEMPTY_TH = 2,
    parameter fifo_mode_e MODE      = FIFO_STD
) (
    input logic              clk,
    input logic              rst,
    fifo_sync_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
        $error("fifo_sync_param: AFULL_TH must lie in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_chk_aempty
        $error("fifo_sync_param: AEMPTY_TH must lie in 0..DEPTH-1");
    end

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] count_w;
    logic          empty_w, full_w;
    logic          wr_ok, rd_ok;
    logic          ovf_q, udf_q;
    logic [DW-1:0] ram_rdata;

    // Extra MSB on each pointer separates "equal and empty" from "equal and full".
    assign empty_w = (wr_ptr == rd_ptr);
    assign full_w  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_w = CW'(wr_ptr - rd_ptr);

    assign wr_ok = bus.we && !full_w;
    assign rd_ok = bus.re && !empty_w;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
            ovf_q <= bus.we && full_w;
            udf_q <= bus.re && empty_w;
        end
    end

    fifo_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.din),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [DW-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)        dout_q <= '0;
            else if (rd_ok) dout_q <= ram_rdata;
        end

        assign bus.dout = dout_q;
    end else begin : g_fwft
        // Head of queue is visible without a read; meaningless while empty.
        assign bus.dout = ram_rdata;
    end

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AFULL_C);
    assign bus.almost_empty = (count_w <= AEMPTY_C);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule
